// File: rtl/count_capture_tx.sv
// count_capture_tx
// Read side of the 8-bit start/stop event counter. Every rising edge on the
// asynchronous capture pin snapshots count_in into a small FIFO; queued
// snapshots are sent off-chip as UART 8N1 frames (LSB first) on tx.
//
// Ports:
//   clk         clock
//   rst_n       synchronous, active-low reset
//   count_in    counter value to snapshot (synchronous to clk)
//   capture     asynchronous capture request; rising edge takes a snapshot
//   clear_ovf   synchronous; clears the sticky overflow flag
//   tx          UART serial output, idles high, driven from a register
//   busy        high while a frame is in flight or snapshots are queued
//   overflow    sticky; a snapshot was dropped because the FIFO was full
//   fifo_level  number of queued snapshots (0..FIFO_DEPTH)
module count_capture_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  count_in,
    input  logic                        capture,
    input  logic                        clear_ovf,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned TMR_W = 16;
    localparam logic [TMR_W-1:0] BIT_LAST = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Capture synchronizer and rising-edge detector
    // ------------------------------------------------------------------
    logic s1_q, s2_q, s3_q;
    logic capture_evt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= capture;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // One event per rising edge no matter how long capture stays high.
    assign capture_evt = s2_q & ~s3_q;

    // ------------------------------------------------------------------
    // Snapshot FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             fifo_full, fifo_empty;
    logic             push, pop, drop;
    logic             ovf_q, ovf_d;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    assign fifo_full  = (level_q == LVL_FULL);
    assign fifo_empty = (level_q == '0);

    // The transmitter takes the head whenever it is idle and data waits.
    assign pop  = (state_q == IDLE) && !fifo_empty;
    // A full FIFO still accepts a snapshot when the head leaves at the
    // same edge; the write lands in the slot being vacated.
    assign push = capture_evt && (!fifo_full || pop);
    assign drop = capture_evt && fifo_full && !pop;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Setting wins over clearing so a drop is never silently lost.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= count_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    // tx_d is the level for the next bit period, so tx changes exactly at
    // bit boundaries straight out of a flop.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = START;
                    shift_d = mem_q[rd_ptr_q];
                    timer_d = BIT_LAST;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (timer_q == '0) begin
                    state_d   = DATA;
                    timer_d   = BIT_LAST;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            DATA: begin
                if (timer_q == '0) begin
                    timer_d = BIT_LAST;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_count_capture_tx.sv
// Testbench for count_capture_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A queue-based reference model predicts tx/busy/overflow/fifo_level every
// cycle from frame start times; a UART receiver decodes tx independently
// and the decoded bytes are compared with the values the bench drove.
module tb_count_capture_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] count_in = 8'h00;
    logic       capture = 1'b0;
    logic       clear_ovf = 1'b0;
    logic       tx, busy, overflow;
    logic [2:0] fifo_level;

    count_capture_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_in   (count_in),
        .capture    (capture),
        .clear_ovf  (clear_ovf),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: snapshot queue plus the start time of the current
    // frame. A frame lasts FRAME cycles; the next one may start one cycle
    // after it ends. Capture edges become pushes two edges after the
    // first edge that sees capture high.
    // ------------------------------------------------------------------
    byte unsigned mq[$];
    byte unsigned m_popped[$];
    bit           m_ovf = 1'b0;
    bit           m_in_frame = 1'b0;
    int           m_start = 0;
    byte unsigned m_byte = 0;
    bit           h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    always @(posedge clk) begin : model
        bit evt, idle, pop_now, full;
        cyc++;
        if (!rst_n) begin
            mq.delete();
            m_ovf = 1'b0;
            m_in_frame = 1'b0;
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        end else begin
            evt     = h2 && !h3;
            idle    = !m_in_frame || (cyc > m_start + FRAME);
            full    = (mq.size() == DEPTH);
            pop_now = idle && (mq.size() > 0);
            if (pop_now) begin
                m_byte = mq.pop_front();
                m_popped.push_back(m_byte);
                m_in_frame = 1'b1;
                m_start = cyc;
            end
            if (evt) begin
                if (!full || pop_now) mq.push_back(count_in);
                else m_ovf = 1'b1;
            end
            if (clear_ovf && !(evt && full && !pop_now)) m_ovf = 1'b0;
            h3 = h2; h2 = h1; h1 = capture;
        end
    end

    int max_lvl = 0;

    always @(negedge clk) begin : cycle_check
        bit   act;
        int   idx;
        logic exp_tx;
        if (chk_en) begin
            act    = m_in_frame && (cyc < m_start + FRAME);
            exp_tx = 1'b1;
            if (act) begin
                idx = (cyc - m_start) / CPB;
                if (idx == 0) exp_tx = 1'b0;
                else if (idx <= 8) exp_tx = m_byte[idx-1];
            end
            check("tx_cycle", tx, exp_tx);
            check("busy_cycle", busy, act || (mq.size() > 0));
            check("overflow_cycle", overflow, m_ovf);
            check("level_cycle", fifo_level, mq.size());
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
        end
    end

    // ------------------------------------------------------------------
    // UART receiver: samples each bit in its middle.
    // ------------------------------------------------------------------
    byte unsigned rx_q[$];
    int           start_cyc[$];

    initial begin : uart_rx
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                start_cyc.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                check("start_bit", tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                check("stop_bit", tx, 1'b1);
                rx_q.push_back(b);
                $display("frame rx: data=0x%02h start_cycle=%0d", b, start_cyc[$]);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    byte unsigned exp_q[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cap_pulse(input logic [7:0] v, input int hi, input int lo);
        count_in = v;
        capture  = 1'b1;
        tick(hi);
        capture  = 1'b0;
        tick(lo);
    endtask

    task automatic wait_idle(input string tag, output int t_done);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 2000) begin
            tick(1);
            k++;
        end
        t_done = cyc;
        check(tag, k < 2000, 1'b1);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check({tag, "_data"}, rx_q[i], exp_q[i]);
    endtask

    task automatic count_low(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (tx !== 1'b1) lows++;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : main
        int t_fall, t_done, lows, n0, p;
        byte unsigned v;

        // Reset
        rst_n = 1'b0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_level", fifo_level, 3'd0);
        count_low(100, lows);
        check("idle_tx_high", lows, 0);

        // Single capture held for 20 cycles
        rx_q.delete(); exp_q.delete();
        count_in = 8'hA5;
        capture = 1'b1;
        tick(3);
        check("latency_before_E3", tx, 1'b1);
        tick(1);
        check("latency_at_E3", tx, 1'b0);
        t_fall = cyc;
        tick(16);
        capture = 1'b0;
        wait_idle("single_timeout", t_done);
        check("single_busy_len", t_done - t_fall, FRAME);
        tick(5);
        exp_q.push_back(8'hA5);
        check_rx("single");

        // Back-to-back captures
        rx_q.delete(); exp_q.delete();
        max_lvl = 0;
        n0 = start_cyc.size();
        for (int i = 1; i <= 3; i++) begin
            cap_pulse(8'(i), 2, 2);
            exp_q.push_back(8'(i));
        end
        tick(2);
        wait_idle("b2b_timeout", t_done);
        tick(5);
        check_rx("b2b");
        check("b2b_frames", start_cyc.size() - n0, 3);
        if (start_cyc.size() - n0 >= 3) begin
            check("b2b_gap1", start_cyc[n0+1] - start_cyc[n0], FRAME + 1);
            check("b2b_gap2", start_cyc[n0+2] - start_cyc[n0+1], FRAME + 1);
        end
        check("b2b_peak_level", (max_lvl >= 2) && (max_lvl <= 3), 1'b1);

        // Overflow: 6 captures during the first frame
        rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            v = 8'($urandom);
            cap_pulse(v, 2, 2);
            if (i < 5) exp_q.push_back(v);
        end
        check("ovf_level_full", fifo_level, 3'd4);
        check("ovf_set", overflow, 1'b1);
        tick(10);
        check("ovf_sticky", overflow, 1'b1);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        wait_idle("ovf_timeout", t_done);
        tick(5);
        check_rx("ovf");

        // Full FIFO with push and pop on the same edge
        rx_q.delete(); exp_q.delete();
        n0 = start_cyc.size();
        for (int i = 0; i < 5; i++) begin
            v = 8'($urandom);
            cap_pulse(v, 2, 2);
            exp_q.push_back(v);
        end
        check("simul_frame_started", start_cyc.size() > n0, 1'b1);
        if (start_cyc.size() > n0) begin
            p = start_cyc[n0];
            while (cyc < p + 38) tick(1);
            v = 8'($urandom);
            exp_q.push_back(v);
            count_in = v;
            capture = 1'b1;
            tick(2);
            check("simul_level_before", fifo_level, 3'd4);
            capture = 1'b0;
            tick(1);
            check("simul_level_after", fifo_level, 3'd4);
            check("simul_no_overflow", overflow, 1'b0);
        end
        wait_idle("simul_timeout", t_done);
        tick(5);
        check_rx("simul");

        // Reset in the middle of DATA bit 3
        n0 = start_cyc.size();
        for (int i = 0; i < 3; i++) cap_pulse(8'($urandom), 2, 2);
        check("rstmid_frame_started", start_cyc.size() > n0, 1'b1);
        if (start_cyc.size() > n0) begin
            p = start_cyc[n0];
            while (cyc < p + 17) tick(1);
            rst_n = 1'b0;
            tick(1);
            check("rstmid_tx", tx, 1'b1);
            check("rstmid_level", fifo_level, 3'd0);
            check("rstmid_busy", busy, 1'b0);
            tick(1);
            rst_n = 1'b1;
        end
        count_low(200, lows);
        check("rstmid_no_frames", lows, 0);

        // Randomised captures and clears against the model
        rx_q.delete();
        m_popped.delete();
        for (int i = 0; i < 600; i++) begin
            capture   = ($urandom_range(0, 3) == 0);
            count_in  = 8'($urandom);
            clear_ovf = ($urandom_range(0, 29) == 0);
            tick(1);
        end
        capture = 1'b0;
        clear_ovf = 1'b0;
        tick(4);
        wait_idle("random_timeout", t_done);
        tick(5);
        exp_q = m_popped;
        check_rx("random");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/count_capture_tx.md
Name: count_capture_tx

Overview:
- Read side of the 8-bit start/stop event counter: takes snapshots of the counter's output bus and sends them off-chip.
- Each rising edge on an external capture pin latches the current 8-bit count into a small FIFO.
- Queued snapshots are sent as UART 8N1 frames on a single tx pin.
- Sits in the TT top level, fed by the counter's output bus; capture comes from a dedicated input and tx drives a dedicated output.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 4, snapshot FIFO entries; power of two, >=2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- count_in  input  8  counter value to snapshot; synchronous to clk.
- capture  input  1  asynchronous capture request; rising edge triggers a snapshot.
- clear_ovf  input  1  synchronous; clears the overflow flag.
- tx  output  1  UART serial out; idles high.
- busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- overflow  output  1  sticky; a capture was dropped because the FIFO was full.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of queued snapshots.

Behaviour:
- Reset: all of the following are synchronous on a clk edge while rst_n=0.
  - Outputs: tx=1, busy=0, overflow=0, fifo_level=0.
  - Internal state: FSM=IDLE, FIFO pointers=0, sync/edge regs=0, bit timer=0.
  - Reset asserted mid-frame aborts the frame: tx=1 at that edge, queued data is discarded.
- Capture path:
  - capture passes through a 2-flop synchronizer (s1, s2), then a delay flop s3.
  - Edge event = s2 & ~s3.
  - Capture held high for many cycles produces exactly one event.
  - Pulses shorter than one clk period may be missed; this is acceptable.
- Push:
  - On an edge event, the value of count_in in that cycle is written to the FIFO at the clk edge that ends the cycle.
  - Timing, counting from edge E0 (the first clk edge that samples capture=1): s2=1 after E1, push at E2, count_in sampled in the cycle preceding E2.
  - If FIFO is full at the push edge and no pop occurs at that edge: data dropped, overflow<=1.
  - If full and a pop occurs at the same edge: push accepted, level unchanged.
- Overflow:
  - Sticky flag.
  - clear_ovf=1 clears it at the next edge.
  - A drop and clear_ovf in the same cycle leave overflow=1 (set wins).
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If fifo_level>0, pop the head at the edge, load the shift register, go to START with tx=0 and bit timer=CLKS_PER_BIT-1.
  - Every state holds for CLKS_PER_BIT cycles; the bit timer counts down to 0.
  - START -> DATA: 8 bits, LSB first, bit index 0..7.
  - DATA -> STOP: tx=1 for CLKS_PER_BIT cycles.
  - STOP -> IDLE.
  - Frame = 10*CLKS_PER_BIT cycles with tx driven from a register (glitch-free).
  - Back-to-back: if the FIFO is non-empty at the end of STOP, IDLE lasts exactly 1 cycle, then START. Inter-frame gap = CLKS_PER_BIT+1 cycles of tx=1 (stop bit plus one IDLE cycle).
- Latency: an empty-FIFO capture at E0 gives push at E2, pop at E3, tx falls at E3.
- Simultaneous push and pop:
  - Level unchanged.
  - A push into an empty FIFO cannot coincide with a pop; the pop follows 1 cycle later.
- Pointers: wrap modulo FIFO_DEPTH; fifo_level in 0..FIFO_DEPTH.
- busy = (FSM != IDLE) | (fifo_level != 0).

Test Plan:
- Reset, CLKS_PER_BIT=4: hold rst_n=0 for 3 cycles, release -> tx=1, busy=0, overflow=0, fifo_level=0; tx stays 1 for 100 cycles.
- Single capture: count_in=8'hA5, capture rises before E0 and is held 20 cycles -> tx falls at E3; bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each; stop bit high; exactly one frame; busy drops at the end of STOP.
- Back-to-back: 3 capture pulses with count_in=8'h01, 8'h02, 8'h03 within 10 cycles -> three frames in order 01, 02, 03; each gap = 5 cycles of tx=1; fifo_level peaks at 2 or 3 and never exceeds 3.
- Overflow, FIFO_DEPTH=4: 6 captures during the first frame -> first popped, 4 queued, 1 dropped; overflow=1 and stays high; clear_ovf pulse -> 0 next cycle; 5 frames total with correct values.
- Full with simultaneous pop: FIFO full, capture timed so the push edge equals the pop edge -> no drop, overflow stays 0, level stays 4.
- Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1 and fifo_level=0 at the next edge; no further frames after release.
